seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 100000; clk cycles each digit is driven (>=1).
REQ-002 SHALL have parameter GUARD, default 1000; clk cycles with all digits off between digits, for anti-ghosting (>=1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write request into the shadow digit buffer.
REQ-006 wr_ready  output  1  shadow buffer accepts writes.
REQ-007 wr_addr  input  3  digit index 0..7.
REQ-008 wr_data  input  5  {blank, hex[3:0]}; blank=1 keeps the digit dark.
REQ-009 commit  input  1  one-cycle pulse; request copy of shadow to active buffer at the next frame boundary.
REQ-010 enable  output  8  digit enables, active-low, one-hot-low or all ones.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 frame_done  output  1  one-cycle pulse at end of digit 7 drive.

Function
REQ-013 SHALL run a 2-state FSM, DRIVE and GUARD, with a dwell counter and 3-bit scan index idx.
- DRIVE lasts exactly DWELL cycles, then goes to GUARD.
- GUARD lasts exactly GUARD cycles, then goes to DRIVE with idx+1 mod 8 (7 wraps to 0).
REQ-014 In DRIVE, enable SHALL be all ones except bit idx=0 when active[idx].blank=0; otherwise enable is all ones. In GUARD, enable SHALL be 8'hFF.
REQ-015 seg SHALL be the active-low hex decode of active[idx].hex in DRIVE with blank=0, else 7'h7F.
- Required codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-016 enable and seg SHALL be registered; they change on the same edge as the FSM state and idx.
REQ-017 A write SHALL be accepted when wr_valid&&wr_ready; shadow[wr_addr] updates on that edge. wr_valid without wr_ready is ignored; no retry is stored.
REQ-018 commit SHALL set commit_pending; while commit_pending=1, wr_ready SHALL be 0.
REQ-019 A write and a commit in the same cycle: the write SHALL be accepted and included in the commit.
REQ-020 frame_done SHALL pulse on the cycle the FSM leaves DRIVE with idx=7.
- If commit_pending is 1 (or commit is asserted that cycle), active<=shadow for all 8 digits and commit_pending clears on that same edge.
- The copy SHALL never occur mid-frame, so no tearing.
REQ-021 commit while commit_pending=1 SHALL have no further effect.

Reset
REQ-022 rst SHALL take priority over all inputs. While rst=1 and on the first cycle after release, the block SHALL hold:
- state=GUARD, idx=7, counter=0
- enable=8'hFF, seg=7'h7F, frame_done=0
- commit_pending=0, wr_ready=1
- shadow and active all 5'h10 (blank)
REQ-023 After release, the first DRIVE SHALL start with idx=0 exactly GUARD cycles later.
REQ-024 rst asserted mid-frame SHALL abort the frame and discard a pending commit.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the digit count (8) and the blank code 5'h10.
REQ-026 Hex decode SHALL be a sub-module hex7seg (4-bit in, 7-bit active-low out), combinational, registered in the parent.
REQ-027 Counter width SHALL be $clog2(max(DWELL,GUARD)).

Verification (DWELL=4, GUARD=1; frame = 40 cycles)
REQ-028 Reset: check enable=FF and seg=7F while rst=1. After release, enable=FE exactly 1 cycle later only if digit 0 is unblanked; otherwise enable stays FF.
REQ-029 Write digits 0..7 = 0..7 and commit. Check frame_done at end of digit 7, then active updates. The next frame shows enable FE,FD,...,7F, each for 4 cycles, with FF for 1 cycle between, and seg 40,79,24,30,19,12,02,78.
REQ-030 Commit mid-frame with a changed digit 3 = A. Check the current frame still shows the old value, the next frame shows seg=08, and wr_ready=0 from commit until frame_done.
REQ-031 Assert wr_valid while wr_ready=0. Check the write is dropped and shadow is unchanged after commit clears.
REQ-032 Write and commit in the same cycle (digit 5 = F). Check seg=0E for digit 5 after the boundary. A blanked digit 6 shows enable=FF and seg=7F for its slot.
REQ-033 Assert rst during idx=4 with a commit pending. Check idx restarts at 0, the commit is discarded, and all digits are blank.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 8-digit seven-segment scanner.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    // Digit buffer entry is {blank, hex[3:0]}; this code keeps a digit dark.
    localparam logic [4:0] BLANK_CODE = 5'h10;
    localparam logic [7:0] ENABLE_OFF = 8'hFF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex to active-low seven-segment decode, bit order {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with shadow/active double buffering;
// the shadow is copied to the active buffer only at a frame boundary to avoid tearing.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 100000,
    parameter int GUARD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       commit,
    output logic [7:0] enable,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int MAX_CYC = max_int(DWELL, GUARD);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [7:0] enable_reg, enable_next;
    logic [6:0] seg_reg, seg_next;
    logic       frame_done_reg, frame_done_next;
    logic       commit_pending_reg;

    logic [4:0] shadow_reg  [NUM_DIGITS];
    logic [4:0] shadow_next [NUM_DIGITS];
    logic [4:0] active_reg  [NUM_DIGITS];

    logic       wr_fire;
    logic       frame_end;
    logic       do_copy;
    logic [4:0] digit_sel;
    logic [6:0] dec_seg;
    logic       lit;

    assign wr_ready   = ~commit_pending_reg;
    assign wr_fire    = wr_valid & ~commit_pending_reg;
    assign enable     = enable_reg;
    assign seg        = seg_reg;
    assign frame_done = frame_done_reg;

    // Last drive cycle of digit 7: the edge ending it is the only point where the copy may happen.
    assign frame_end = (state_reg == ST_DRIVE) && (idx_reg == LAST_IDX) && (cnt_reg == DWELL_LAST);
    assign do_copy   = frame_end && (commit_pending_reg || commit);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (state_reg == ST_DRIVE) begin
            if (cnt_reg == DWELL_LAST) begin
                state_next = ST_GUARD;
                cnt_next   = '0;
            end
        end else begin
            if (cnt_reg == GUARD_LAST) begin
                state_next = ST_DRIVE;
                idx_next   = idx_reg + IDX_W'(1);
                cnt_next   = '0;
            end
        end
    end

    // Outputs are computed from the upcoming state so they switch on the same edge as the FSM.
    assign digit_sel = active_reg[idx_next];
    assign lit       = (state_next == ST_DRIVE) && !digit_sel[4];
    assign seg_next  = lit ? dec_seg : SEG_OFF;
    assign frame_done_next = (state_next == ST_DRIVE) && (idx_next == LAST_IDX)
                             && (cnt_next == DWELL_LAST);

    hex7seg u_hex7seg (
        .hex   (digit_sel[3:0]),
        .seg_n (dec_seg)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign shadow_next[gi] = (wr_fire && (wr_addr == IDX_W'(gi))) ? wr_data : shadow_reg[gi];
            assign enable_next[gi] = !(lit && (idx_next == IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_GUARD;
            idx_reg            <= LAST_IDX;
            cnt_reg            <= '0;
            enable_reg         <= ENABLE_OFF;
            seg_reg            <= SEG_OFF;
            frame_done_reg     <= 1'b0;
            commit_pending_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i] <= BLANK_CODE;
                active_reg[i] <= BLANK_CODE;
            end
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            enable_reg     <= enable_next;
            seg_reg        <= seg_next;
            frame_done_reg <= frame_done_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i] <= shadow_next[i];
                if (do_copy) begin
                    active_reg[i] <= shadow_next[i];
                end
            end
            // A commit arriving on the boundary cycle is served immediately and never pends.
            if (do_copy) begin
                commit_pending_reg <= 1'b0;
            end else if (commit) begin
                commit_pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts every output cycle.
module tb_seg_scan_ctrl;

    localparam int DW    = 4;
    localparam int GD    = 1;
    localparam int SLOT  = DW + GD;
    localparam int FRAME = 8 * SLOT;
    localparam int FD_POS = 7 * SLOT + DW - 1;

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       commit;
    logic [7:0] enable;
    logic [6:0] seg;
    logic       frame_done;

    exp_t exp_q [$];
    int   checks = 0;
    int   failures = 0;
    int   timeout_cnt = 0;
    int   model_k = 0;
    bit   end_req = 0;
    bit   end_ack = 0;

    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];
    bit         m_pending;
    logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(.DWELL(DW), .GUARD(GD)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .enable     (enable),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: display content follows purely from the cycle count since reset.
    initial begin
        exp_t e;
        bit   at_boundary;
        int   p, d, w;
        forever begin
            @(posedge clk);
            if (rst) begin
                model_k   = 0;
                m_pending = 0;
                for (int i = 0; i < 8; i++) begin
                    m_shadow[i] = 5'h10;
                    m_active[i] = 5'h10;
                end
                e = '{8'hFF, 7'h7F, 1'b0, 1'b1};
            end else begin
                at_boundary = (model_k >= 1) && (((model_k - 1) % FRAME) == FD_POS);
                if (wr_valid && !m_pending) begin
                    m_shadow[wr_addr] = wr_data;
                    $display("t=%0t write digit %0d <= %02h", $time, wr_addr, wr_data);
                end else if (wr_valid) begin
                    $display("t=%0t write digit %0d dropped (commit pending)", $time, wr_addr);
                end
                if (at_boundary && (m_pending || commit)) begin
                    for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                    m_pending = 0;
                    $display("t=%0t frame boundary: active buffer updated", $time);
                end else if (commit && !m_pending) begin
                    m_pending = 1;
                    $display("t=%0t commit requested", $time);
                end
                model_k++;
                p = (model_k - 1) % FRAME;
                d = p / SLOT;
                w = p % SLOT;
                if (w < DW && !m_active[d][4]) begin
                    e.en  = 8'(~(8'd1 << d));
                    e.seg = seg_code[m_active[d][3:0]];
                end else begin
                    e.en  = 8'hFF;
                    e.seg = 7'h7F;
                end
                e.fd  = (d == 7) && (w == DW - 1);
                e.rdy = !m_pending;
            end
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the opposite edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("enable",     32'(enable),     32'(e.en));
                chk("seg",        32'(seg),        32'(e.seg));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("wr_ready",   32'(wr_ready),   32'(e.rdy));
            end
            if (end_req && !end_ack) begin
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                chk("wait_timeouts", 32'(timeout_cnt), 32'd0);
                end_ack = 1;
            end
        end
    end

    task automatic set_in(input logic v, input logic [2:0] a, input logic [4:0] dat, input logic c);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = dat;
        commit   = c;
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic wait_pos(input int lo, input int hi);
        int n;
        n = 0;
        while (!(model_k >= 1 && ((model_k - 1) % FRAME) >= lo && ((model_k - 1) % FRAME) <= hi)) begin
            @(negedge clk);
            n++;
            if (n > 3 * FRAME) begin
                timeout_cnt++;
                $display("t=%0t timeout waiting for frame position %0d..%0d", $time, lo, hi);
                return;
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Digits 0..7 = 0..7, then commit and watch the next frame.
        for (int d = 0; d < 8; d++) begin
            set_in(1'b1, 3'(d), 5'(d), 1'b0);
            @(negedge clk);
        end
        set_in(1'b0, 3'd0, 5'd0, 1'b1);
        @(negedge clk);
        idle();
        wait_pos(FD_POS, FD_POS);
        repeat (FRAME + 2) @(negedge clk);

        // Mid-frame change of digit 3, then writes attempted while the commit pends.
        wait_pos(6, 8);
        set_in(1'b1, 3'd3, 5'h0A, 1'b0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 5'd0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd1, 5'h09, 1'b0);
            @(negedge clk);
        end
        idle();
        wait_pos(FD_POS, FD_POS);
        repeat (FRAME + 2) @(negedge clk);

        // Blank digit 6, then write digit 5 = F together with commit on the boundary cycle.
        set_in(1'b1, 3'd6, 5'h1C, 1'b0);
        @(negedge clk);
        idle();
        wait_pos(FD_POS, FD_POS);
        set_in(1'b1, 3'd5, 5'h0F, 1'b1);
        @(negedge clk);
        idle();
        repeat (FRAME + 2) @(negedge clk);

        // Reset while digit 4 drives with a commit pending.
        wait_pos(1, 3);
        set_in(1'b1, 3'd2, 5'h05, 1'b1);
        @(negedge clk);
        idle();
        wait_pos(4 * SLOT, 4 * SLOT + 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 4) @(negedge clk);
        set_in(1'b1, 3'd0, 5'h08, 1'b1);
        @(negedge clk);
        idle();
        repeat (2 * FRAME) @(negedge clk);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            set_in(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                   {($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))},
                   ($urandom_range(0, 24) == 0));
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        repeat (FRAME) @(negedge clk);

        end_req = 1;
        n = 0;
        while (!end_ack && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!end_ack) begin
            $display("FAIL end_of_test monitor_ack got=0 expected=1");
            $fatal(1, "monitor did not acknowledge end of test");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
